// File: rtl/four_bit_full_adder_pkg.sv
// Shared constants for the ripple-carry adder slice.
package four_bit_full_adder_pkg;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/four_bit_full_adder_full_adder.sv
// One-bit full adder cell; the ripple chain in four_bit_full_adder is built from these.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/four_bit_full_adder.sv
// Ripple-carry adder with a purely combinational sum/carry and one registered result stage.
module four_bit_full_adder
  import four_bit_full_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  output logic [WIDTH-1:0] s,
  output logic             carry,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic [WIDTH-1:0] s_q,
  output logic             carry_q,
  output logic             zero_q,
  output logic             ovf_q,
  output logic             out_valid
);

  logic [WIDTH:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .s   (s[i]),
      .cout(c[i+1])
    );
  end

  assign carry = c[WIDTH];

  // Register stage: the combinational chain above must stay independent of clk/rst/in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q       <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b1;
      ovf_q     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s_q     <= s;
        carry_q <= carry;
        zero_q  <= ~(|{carry, s});
        ovf_q   <= c[WIDTH-1] ^ c[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_four_bit_full_adder.sv
// Directed and exhaustive checks of the adder's combinational and registered paths.
module tb_four_bit_full_adder;

  typedef struct packed {
    logic [3:0] s;
    logic       c;
    logic       z;
    logic       o;
  } res_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       cin = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] s;
  logic       carry;
  logic [3:0] s_q;
  logic       carry_q;
  logic       zero_q;
  logic       ovf_q;
  logic       out_valid;

  int   total = 0;
  int   bad = 0;
  res_t sb[$];
  res_t m;

  four_bit_full_adder #(.WIDTH(4)) dut (
    .s        (s),
    .carry    (carry),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .s_q      (s_q),
    .carry_q  (carry_q),
    .zero_q   (zero_q),
    .ovf_q    (ovf_q),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [3:0] ta, input logic [3:0] tb, input logic tc);
    res_t r;
    logic [4:0] sum;
    int         ssum;
    sum  = {1'b0, ta} + {1'b0, tb} + {4'b0, tc};
    ssum = int'($signed(ta)) + int'($signed(tb)) + int'(tc);
    r.s  = sum[3:0];
    r.c  = sum[4];
    r.z  = (sum == 5'd0);
    r.o  = (ssum > 7) || (ssum < -8);
    return r;
  endfunction

  // Drive one cycle of stimulus, check the combinational path, then the registered outputs.
  task automatic step(input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                      input logic tiv, input logic trst);
    res_t e;
    @(negedge clk);
    a = ta; b = tb; cin = tc; in_valid = tiv; rst = trst;
    #1;
    e = model(ta, tb, tc);
    chk("comb_s", 32'(s), 32'(e.s));
    chk("comb_carry", 32'(carry), 32'(e.c));
    if (tiv && !trst) sb.push_back(e);
    @(posedge clk);
    #1;
    if (trst) begin
      m = '{s: 4'd0, c: 1'b0, z: 1'b1, o: 1'b0};
      sb.delete();
    end else if (tiv) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $error("FAIL scoreboard_empty observed=0 expected=1");
      end else begin
        m = sb.pop_front();
      end
    end
    chk("out_valid", 32'(out_valid), 32'(tiv && !trst));
    chk("s_q", 32'(s_q), 32'(m.s));
    chk("carry_q", 32'(carry_q), 32'(m.c));
    chk("zero_q", 32'(zero_q), 32'(m.z));
    chk("ovf_q", 32'(ovf_q), 32'(m.o));
  endtask

  initial begin
    m = '{s: 4'd0, c: 1'b0, z: 1'b1, o: 1'b0};
    step(4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    step(4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    chk("reset_zero_q", 32'(zero_q), 32'd1);
    chk("reset_s_q", 32'(s_q), 32'd0);

    step(4'b0100, 4'b0010, 1'b0, 1'b1, 1'b0);
    chk("dir_s_0110", 32'(s), 32'(4'b0110));
    step(4'b0100, 4'b0010, 1'b1, 1'b1, 1'b0);
    chk("dir_s_0111", 32'(s_q), 32'(4'b0111));
    step(4'b1000, 4'b0100, 1'b0, 1'b1, 1'b0);
    chk("dir_s_1100", 32'(s_q), 32'(4'b1100));
    step(4'b1010, 4'b1001, 1'b0, 1'b1, 1'b0);
    chk("dir_carry_0011", 32'({carry_q, s_q}), 32'(5'b10011));
    step(4'b1111, 4'b1111, 1'b1, 1'b1, 1'b0);
    chk("max_sum", 32'({carry_q, s_q}), 32'(5'b11111));
    chk("max_ovf", 32'(ovf_q), 32'd0);
    step(4'b0111, 4'b0001, 1'b0, 1'b1, 1'b0);
    chk("ovf_set", 32'(ovf_q), 32'd1);
    step(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    chk("zero_set", 32'(zero_q), 32'd1);

    step(4'b1000, 4'b0001, 1'b1, 1'b1, 1'b0);
    chk("reg_s_1010", 32'(s_q), 32'(4'b1010));
    step(4'b0011, 4'b0011, 1'b0, 1'b0, 1'b0);
    chk("hold_s_1010", 32'(s_q), 32'(4'b1010));

    // Reset beats in_valid; combinational outputs keep tracking the operands.
    step(4'b0110, 4'b0101, 1'b1, 1'b1, 1'b1);
    chk("rst_prio_valid", 32'(out_valid), 32'd0);

    for (int ci = 0; ci < 2; ci++)
      for (int ai = 0; ai < 16; ai++)
        for (int bi = 0; bi < 16; bi++)
          step(4'(ai), 4'(bi), 1'(ci), 1'b1, 1'b0);

    step(4'b0101, 4'b0101, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/four_bit_full_adder.md
# four_bit_full_adder

Parameterisable ripple-carry binary adder, default 4 bits, computing a + b + cin. It provides a combinational sum/carry path and a registered copy of the same result with valid tracking and status flags. It is the arithmetic primitive inside the BCD adder: one instance forms the binary sum, and a second instance adds the decimal correction (0110) to that sum.

## Interface
Parameters:
- WIDTH, 4, operand and sum width in bits (≥1).

Ports (clock and reset first):
- clk  input  1  single clock; all registers update on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- s  output  WIDTH  combinational sum, (a + b + cin) mod 2^WIDTH.
- carry  output  1  combinational carry-out of the MSB.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry-in.
- in_valid  input  1  capture a, b and cin into the output register this cycle.
- s_q  output  WIDTH  registered sum.
- carry_q  output  1  registered carry.
- zero_q  output  1  registered flag; 1 when the registered {carry, s} is all zeros.
- ovf_q  output  1  registered two's-complement overflow flag, carry into MSB XOR carry out of MSB.
- out_valid  output  1  registered outputs hold a fresh result.

Port order is fixed: s, carry, a, b, cin come first, in that order, so existing positional instantiations stay valid. The remaining ports follow in the order listed above.

## Operation
- Combinational path: ripple chain of WIDTH one-bit full adders.
  - c[0] = cin.
  - s[i] = a[i] ^ b[i] ^ c[i].
  - c[i+1] = a[i]&b[i] | a[i]&c[i] | b[i]&c[i].
  - carry = c[WIDTH].
- The combinational path has no dependence on clk, rst or in_valid. The BCD adder chains two instances combinationally and relies on this.
- Full result {carry, s} = a + b + cin exactly. The maximum is 2^(WIDTH+1) − 1 (15+15+1 = 31 → carry=1, s=1111).
- Registered path, when in_valid=1 at a clock edge:
  - s_q ← s, carry_q ← carry.
  - zero_q ← ({carry, s} == 0).
  - ovf_q ← c[WIDTH-1] ^ c[WIDTH].
  - out_valid ← 1.
- When in_valid=0: s_q, carry_q, zero_q and ovf_q hold their values; out_valid ← 0.
- Operands are unsigned. ovf_q is informational only, for signed callers.

## Timing
- Combinational outputs s and carry: zero cycles, purely combinational.
- Registered outputs: one-cycle latency. The result of operands presented with in_valid at edge N is visible after edge N.
- Reset, when rst=1 at an edge:
  - s_q=0, carry_q=0, zero_q=1, ovf_q=0, out_valid=0.
  - rst has priority over in_valid.
- Reset asserted mid-stream drops the pending capture. out_valid is low the following cycle.
- Back-to-back in_valid gives one new result per cycle, with no bubbles.

## Structure
- Sub-module full_adder (a, b, cin → s, cout), instantiated WIDTH times in a generate loop.
- No shared package is needed. If the BCD adder wants shared constants, BCD_CORRECTION = 4'b0110 and BCD_MAX_DIGIT = 9 belong in a bcd_pkg.
- The top contains only the generate chain, the flag logic and one register stage.

## Test plan
- Combinational: a=0100, b=0010, cin=0 → s=0110, carry=0. With cin=1 → s=0111.
- Combinational: a=1000, b=0100, cin=0 → s=1100, carry=0. a=1010, b=1001, cin=0 → s=0011, carry=1.
- Wrap and edge cases:
  - a=1111, b=1111, cin=1 → s=1111, carry=1, ovf_q=0 after the edge.
  - a=0111, b=0001, cin=0 → s=1000, ovf_q=1.
  - a=0, b=0, cin=0 → zero_q=1.
- Registered path: in_valid=1 with a=1000, b=0001, cin=1 → next cycle s_q=1010, carry_q=0, out_valid=1. in_valid=0 the cycle after → out_valid=0 and s_q holds.
- Reset: assert rst together with in_valid=1 → next cycle all registered outputs at their reset values, out_valid=0. The combinational s and carry still track the inputs.
- Exhaustive: all 2×16×16 input combinations → {carry, s} = a + b + cin. In a BCD-adder wrapper, 8+4 yields digit 0010 with cout=1.
